data_mem_responder: RTL and testbench

- Memory-side responder for the core's data bus (req/gnt/rvalid protocol).
- Accepts one request per cycle from the load/store unit, performs byte-masked writes or word reads on an internal word-addressed RAM, and returns in-order responses after a fixed latency.
- Sits at the memory end of the data port and is used as the data memory in simulation and FPGA builds.
- Supports programmable grant stall, for exercising LSU handshake robustness.

---
 rtl/riscv_cpu_pkg.sv | 42 ++++
 rtl/data_mem_responder_pipe.sv | 47 ++++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_cpu_pkg.sv
// Shared core types and constants; this slice carries the data-memory responder additions.
package riscv_cpu_pkg;

    localparam int unsigned DMEM_DATA_WIDTH = 32;
    localparam int unsigned DMEM_BE_WIDTH   = DMEM_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        DMEM_IDLE  = 1'b0,
        DMEM_STALL = 1'b1
    } dmem_state_e;

    typedef struct packed {
        logic                       valid;
        logic                       err;
        logic [DMEM_DATA_WIDTH-1:0] rdata;
    } dmem_resp_t;

    localparam dmem_resp_t DMEM_RESP_IDLE = '{
        valid: 1'b0,
        err:   1'b0,
        rdata: {DMEM_DATA_WIDTH{1'b0}}
    };

    // Replace only the byte lanes selected by be.
    function automatic logic [DMEM_DATA_WIDTH-1:0] dmem_be_merge(
        input logic [DMEM_DATA_WIDTH-1:0] old_word,
        input logic [DMEM_DATA_WIDTH-1:0] new_word,
        input logic [DMEM_BE_WIDTH-1:0]   be
    );
        logic [DMEM_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(DMEM_BE_WIDTH); i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                merged[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_pipe.sv
// Fixed-latency response shift register; stage 0 is loaded every cycle, the last stage drives the bus.
module data_mem_resp_pipe
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned RESP_LATENCY = 1,
    parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    input  logic                  in_err_i,
    input  logic [DATA_WIDTH-1:0] in_rdata_i,
    output logic                  out_valid_o,
    output logic                  out_err_o,
    output logic [DATA_WIDTH-1:0] out_rdata_o
);

    dmem_resp_t stage_r [RESP_LATENCY];
    dmem_resp_t stage_in_s;

    // Pack the incoming response into the stage format.
    always_comb begin
        stage_in_s       = DMEM_RESP_IDLE;
        stage_in_s.valid = in_valid_i;
        stage_in_s.err   = in_err_i;
        stage_in_s.rdata = in_rdata_i;
    end

    // Shift register; reset drops every in-flight response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RESP_LATENCY; i++) begin
                stage_r[i] <= DMEM_RESP_IDLE;
            end
        end else begin
            stage_r[0] <= stage_in_s;
            for (int unsigned i = 1; i < RESP_LATENCY; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_valid_o = stage_r[RESP_LATENCY-1].valid;
    assign out_err_o   = stage_r[RESP_LATENCY-1].err;
    assign out_rdata_o = stage_r[RESP_LATENCY-1].rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Data-bus memory responder: optional grant stall, byte-masked word RAM, in-order fixed-latency responses.
module data_mem_responder
    import riscv_cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DMEM_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned GNT_STALL    = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     data_req_i,
    output logic                     data_gnt_o,
    input  logic [DATA_WIDTH-1:0]    data_addr_i,
    input  logic                     data_we_i,
    input  logic [DMEM_BE_WIDTH-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]    data_wdata_i,
    output logic                     data_rvalid_o,
    output logic [DATA_WIDTH-1:0]    data_rdata_o,
    output logic                     data_err_o
);

    localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [3:0]  STALL_INIT = (GNT_STALL == 32'd0) ? 4'd0 : 4'(GNT_STALL - 32'd1);

    dmem_state_e           state_r;
    dmem_state_e           state_s;
    logic [3:0]            stall_cnt_r;
    logic [3:0]            stall_cnt_s;
    logic                  gnt_s;
    logic                  grant_s;
    logic [IDX_W-1:0]      word_idx_s;
    logic                  oor_s;
    logic                  addr_unused_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [DATA_WIDTH-1:0] resp_rdata_s;
    logic                  resp_err_s;
    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Grant FSM: with no stall configured the grant is a straight pass-through of req.
    always_comb begin
        state_s     = state_r;
        stall_cnt_s = stall_cnt_r;
        gnt_s       = 1'b0;
        case (state_r)
            DMEM_IDLE: begin
                if (GNT_STALL == 32'd0) begin
                    gnt_s = data_req_i;
                end else if (data_req_i) begin
                    stall_cnt_s = STALL_INIT;
                    state_s     = DMEM_STALL;
                end else begin
                    state_s = DMEM_IDLE;
                end
            end
            DMEM_STALL: begin
                if (!data_req_i) begin
                    state_s = DMEM_IDLE;
                end else if (stall_cnt_r != 4'd0) begin
                    stall_cnt_s = stall_cnt_r - 4'd1;
                end else begin
                    gnt_s   = 1'b1;
                    state_s = DMEM_IDLE;
                end
            end
            default: begin
                state_s     = DMEM_IDLE;
                stall_cnt_s = 4'd0;
            end
        endcase
    end

    // FSM state and stall counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= DMEM_IDLE;
            stall_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign data_gnt_o    = gnt_s;
    assign grant_s       = data_req_i & gnt_s;
    assign word_idx_s    = data_addr_i[IDX_W+1:2];
    assign oor_s         = |data_addr_i[DATA_WIDTH-1:IDX_W+2];
    assign addr_unused_s = ^data_addr_i[1:0];
    assign rd_word_s     = mem_r[word_idx_s];

    // Response payload; zero unless this is an in-range read grant.
    always_comb begin
        resp_err_s   = grant_s & oor_s;
        resp_rdata_s = {DATA_WIDTH{1'b0}};
        if (grant_s && !data_we_i && !oor_s) begin
            resp_rdata_s = rd_word_s;
        end else begin
            resp_rdata_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Word RAM; contents intentionally survive reset.
    always_ff @(posedge clk_i) begin
        if (grant_s && data_we_i && !oor_s) begin
            mem_r[word_idx_s] <= dmem_be_merge(rd_word_s, data_wdata_i, data_be_i);
        end
    end

    data_mem_resp_pipe #(
        .RESP_LATENCY (RESP_LATENCY),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_resp_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (grant_s),
        .in_err_i    (resp_err_s),
        .in_rdata_i  (resp_rdata_s),
        .out_valid_o (data_rvalid_o),
        .out_err_o   (data_err_o),
        .out_rdata_o (data_rdata_o)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four configurations side by side, each tracked by a transaction-level model.
module tb_data_mem_responder;

    localparam int N = 4;

    function automatic int gs_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    function automatic int rl_of(input int k);
        return (k == 2) ? 3 : ((k == 3) ? 4 : 1);
    endfunction

    typedef struct {
        int          k;
        longint      due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [N];
    logic [31:0] addr  [N];
    logic        we    [N];
    logic [3:0]  be    [N];
    logic [31:0] wdata [N];
    logic        gnt   [N];
    logic        rvalid[N];
    logic [31:0] rdata [N];
    logic        err   [N];

    int          total = 0;
    int          bad   = 0;
    longint      cyc   = 0;

    exp_t        eq[$];
    logic [31:0] mm [int];
    int          wait_cnt   [N] = '{default: 0};
    logic [31:0] last_rdata [N] = '{default: 32'd0};
    logic        last_err   [N] = '{default: 1'b0};
    longint      last_cyc   [N] = '{default: 0};
    int          resp_cnt   [N] = '{default: 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < N; k++) begin : g_dut
        data_mem_responder #(
            .DATA_WIDTH   (32),
            .MEM_DEPTH    (1024),
            .GNT_STALL    (gs_of(k)),
            .RESP_LATENCY (rl_of(k))
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .data_req_i    (req[k]),
            .data_gnt_o    (gnt[k]),
            .data_addr_i   (addr[k]),
            .data_we_i     (we[k]),
            .data_be_i     (be[k]),
            .data_wdata_i  (wdata[k]),
            .data_rvalid_o (rvalid[k]),
            .data_rdata_o  (rdata[k]),
            .data_err_o    (err[k])
        );
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
        end
    endtask

    // Model: req must wait gs_of(k) cycles for a grant; a grant produces one response rl_of(k) cycles later.
    initial begin
        exp_t        e;
        int          idx;
        int          key;
        logic        gexp;
        logic        vexp;
        logic        oor;
        logic [31:0] word;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (!rst_n) begin
                    wait_cnt[k] = 0;
                    chk("rst_rvalid", k, 32'(rvalid[k]), 32'd0);
                    chk("rst_rdata", k, rdata[k], 32'd0);
                    chk("rst_err", k, 32'(err[k]), 32'd0);
                end else begin
                    gexp = req[k] && (wait_cnt[k] == gs_of(k));
                    chk("gnt", k, 32'(gnt[k]), 32'(gexp));
                    idx = -1;
                    for (int i = 0; i < eq.size(); i++) begin
                        if (idx < 0 && eq[i].k == k) idx = i;
                    end
                    vexp = (idx >= 0) && (eq[idx].due == cyc);
                    chk("rvalid", k, 32'(rvalid[k]), 32'(vexp));
                    if (rvalid[k] === 1'b1) begin
                        last_rdata[k] = rdata[k];
                        last_err[k]   = err[k];
                        last_cyc[k]   = cyc;
                        resp_cnt[k]++;
                    end
                    if (vexp) begin
                        chk("err", k, 32'(err[k]), 32'(eq[idx].err));
                        if (!$isunknown(eq[idx].rdata)) chk("rdata", k, rdata[k], eq[idx].rdata);
                        eq.delete(idx);
                    end
                    if (gexp) begin
                        oor = addr[k] >= 32'h0000_1000;
                        key = k * 1024 + int'(addr[k][11:2]);
                        word = mm.exists(key) ? mm[key] : 32'hxxxx_xxxx;
                        e.k     = k;
                        e.due   = cyc + rl_of(k);
                        e.err   = oor;
                        e.rdata = (oor || we[k]) ? 32'd0 : word;
                        eq.push_back(e);
                        if (we[k] && !oor) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[k][b]) word[b*8 +: 8] = wdata[k][b*8 +: 8];
                            end
                            mm[key] = word;
                        end
                    end
                    wait_cnt[k] = (req[k] && !gexp) ? wait_cnt[k] + 1 : 0;
                end
            end
            if (!rst_n) eq.delete();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, output int waits, output longint gcyc);
        req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
        waits = 0;
        gcyc  = -1;
        while (waits < 40 && gcyc < 0) begin
            @(negedge clk);
            if (gnt[k] === 1'b1) gcyc = cyc;
            else waits++;
        end
        if (gcyc < 0) chk("gnt_timeout", k, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    initial begin
        int     w;
        int     c;
        longint g;
        longint g0;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b0; addr[k] = 32'd0; we[k] = 1'b0; be[k] = 4'd0; wdata[k] = 32'd0;
        end
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Basic write then read, plus read-after-write on the next cycle
        issue(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, w, g);
        chk("wr_wait", 0, w, 32'd0);
        tick(1);
        chk("wr_resp_rdata", 0, last_rdata[0], 32'd0);
        chk("wr_resp_cnt", 0, resp_cnt[0], 32'd1);
        issue(0, 32'h10, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("rd_data", 0, last_rdata[0], 32'hDEADBEEF);
        chk("rd_err", 0, 32'(last_err[0]), 32'd0);
        issue(0, 32'h14, 1'b1, 4'hF, 32'h01234567, w, g);
        issue(0, 32'h14, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("raw_data", 0, last_rdata[0], 32'h01234567);

        // Byte enables and the be=0000 no-op write
        issue(0, 32'h20, 1'b1, 4'hF, 32'h11223344, w, g);
        issue(0, 32'h20, 1'b1, 4'b0101, 32'hAABBCCDD, w, g);
        issue(0, 32'h20, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("be_merge", 0, last_rdata[0], 32'h11BB33DD);
        c = resp_cnt[0];
        issue(0, 32'h20, 1'b1, 4'b0000, 32'hFFFFFFFF, w, g);
        issue(0, 32'h20, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("be_zero_keep", 0, last_rdata[0], 32'h11BB33DD);
        chk("be_zero_resp", 0, resp_cnt[0] - c, 32'd2);

        // Grant stall of 3 cycles, and a request abandoned during the stall
        issue(1, 32'h30, 1'b1, 4'hF, 32'h55AA55AA, w, g);
        chk("stall_wait", 1, w, 32'd3);
        tick(2);
        c = resp_cnt[1];
        req[1] = 1'b1; addr[1] = 32'h30; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'd0;
        tick(1);
        req[1] = 1'b0;
        tick(6);
        chk("drop_no_resp", 1, resp_cnt[1], c);
        issue(1, 32'h30, 1'b0, 4'h0, 32'd0, w, g);
        chk("stall_wait2", 1, w, 32'd3);
        tick(1);
        chk("drop_ram_kept", 1, last_rdata[1], 32'h55AA55AA);

        // Latency-3 pipelined reads
        issue(2, 32'h0, 1'b1, 4'hF, 32'h00000100, w, g);
        issue(2, 32'h4, 1'b1, 4'hF, 32'h00000200, w, g);
        issue(2, 32'h8, 1'b1, 4'hF, 32'h00000300, w, g);
        tick(4);
        c = resp_cnt[2];
        issue(2, 32'h0, 1'b0, 4'h0, 32'd0, w, g0);
        issue(2, 32'h4, 1'b0, 4'h0, 32'd0, w, g);
        chk("b2b_grant", 2, 32'(g - g0), 32'd1);
        issue(2, 32'h8, 1'b0, 4'h0, 32'd0, w, g);
        tick(4);
        chk("pipe_last_data", 2, last_rdata[2], 32'h00000300);
        chk("pipe_last_cyc", 2, 32'(last_cyc[2] - g0), 32'd5);
        chk("pipe_count", 2, resp_cnt[2] - c, 32'd3);

        // Out-of-range accesses and the last valid word
        issue(0, 32'h0, 1'b1, 4'hF, 32'hCAFEF00D, w, g);
        issue(0, 32'h1000, 1'b1, 4'hF, 32'h12345678, w, g);
        tick(1);
        chk("oor_wr_err", 0, 32'(last_err[0]), 32'd1);
        chk("oor_wr_rdata", 0, last_rdata[0], 32'd0);
        issue(0, 32'h1000, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("oor_rd_err", 0, 32'(last_err[0]), 32'd1);
        chk("oor_rd_rdata", 0, last_rdata[0], 32'd0);
        issue(0, 32'h0, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("oor_alias_kept", 0, last_rdata[0], 32'hCAFEF00D);
        issue(0, 32'hFFC, 1'b1, 4'hF, 32'h5A5A0001, w, g);
        issue(0, 32'hFFE, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        chk("top_word_data", 0, last_rdata[0], 32'h5A5A0001);
        chk("top_word_err", 0, 32'(last_err[0]), 32'd0);

        // Reset while a latency-4 read is in flight
        issue(3, 32'h40, 1'b1, 4'hF, 32'h0BADC0DE, w, g);
        tick(5);
        c = resp_cnt[3];
        issue(3, 32'h40, 1'b0, 4'h0, 32'd0, w, g);
        tick(1);
        rst_n = 1'b0;
        #1;
        chk("async_rvalid", 3, 32'(rvalid[3]), 32'd0);
        chk("async_rdata", 3, rdata[3], 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(6);
        chk("rst_dropped", 3, resp_cnt[3], c);
        issue(3, 32'h40, 1'b0, 4'h0, 32'd0, w, g);
        tick(5);
        chk("post_rst_data", 3, last_rdata[3], 32'h0BADC0DE);
        chk("post_rst_cnt", 3, resp_cnt[3] - c, 32'd1);

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
